// File: rtl/alu_issue_ctrl.sv
// Front-end for the 2-stage ALU: valid/ready commands in, tagged in-order responses out.
// Latency: accept edge N -> rsp_valid after edge N+3. Backpressure: cmd_ready drops once DEPTH entries are allocated.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_valid_in,
    input  logic [15:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_valid_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             err_orphan
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    cmp_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [15:0]      res_mem [DEPTH];
    logic [2:0]       flg_mem [DEPTH];
    logic [DEPTH-1:0] done;

    logic accept;
    logic retire;
    logic pending;
    logic complete;

    assign cmd_ready = (count < CW'(DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign retire    = rsp_valid && rsp_ready;

    // cmp==wr is ambiguous: it means "nothing pending" unless the buffer is
    // full with the oldest entry still waiting for its result.
    assign pending  = (cmp_ptr != wr_ptr) || ((count == CW'(DEPTH)) && !done[cmp_ptr]);
    assign complete = alu_valid_out && pending;

    assign rsp_valid  = done[rd_ptr];
    assign rsp_result = res_mem[rd_ptr];
    assign rsp_flags  = flg_mem[rd_ptr];
    assign rsp_tag    = tag_mem[rd_ptr];
    assign busy       = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_valid_in <= 1'b0;
        end else begin
            alu_valid_in <= accept;
            if (accept) begin
                alu_a  <= cmd_a;
                alu_b  <= cmd_b;
                alu_op <= cmd_op;
            end
        end
    end

    // Accept, completion and retire always touch distinct entries, so their
    // done-bit updates never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            cmp_ptr    <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done       <= '0;
            err_orphan <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
                res_mem[i] <= '0;
                flg_mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                tag_mem[wr_ptr] <= cmd_tag;
                done[wr_ptr]    <= 1'b0;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (retire) begin
                done[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (complete) begin
                res_mem[cmp_ptr] <= alu_result;
                flg_mem[cmp_ptr] <= {alu_overflow, alu_negative, alu_zero};
                done[cmp_ptr]    <= 1'b1;
                cmp_ptr          <= cmp_ptr + PW'(1);
            end else if (alu_valid_out) begin
                err_orphan <= 1'b1;
            end
            count <= count + CW'(accept) - CW'(retire);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 2-stage ALU and an in-order response scoreboard.
module tb_alu_issue_ctrl;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready;
    logic [15:0]      cmd_a, cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [15:0]      alu_a, alu_b;
    logic [2:0]       alu_op;
    logic             alu_valid_in;
    logic [15:0]      alu_result;
    logic             alu_zero, alu_negative, alu_overflow, alu_valid_out;
    logic             rsp_valid, rsp_ready;
    logic [15:0]      rsp_result;
    logic [2:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy, err_orphan;
    logic             force_vo;

    int checks   = 0;
    int failures = 0;

    // entries are {tag, flags, result}
    logic [22:0] sb[$];
    logic [22:0] rsp_log[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid_in(alu_valid_in),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_valid_out(alu_valid_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .busy(busy), .err_orphan(err_orphan)
    );

    // returns {overflow(carry/borrow), negative, zero, result}
    function automatic logic [18:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        logic [16:0] w;
        logic [15:0] r;
        logic        c;
        w = '0;
        r = '0;
        c = 1'b0;
        case (op)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
            3'd1: begin r = a - b; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[3:0];
            3'd6: r = a >> b[3:0];
            default: r = {15'b0, ($signed(a) < $signed(b))};
        endcase
        return {c, r[15], (r == 16'h0000), r};
    endfunction

    // behavioural 2-stage ALU sharing rst_n
    logic        s1_v, s2_v;
    logic [18:0] s1_d, s2_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
        end else begin
            s1_v <= alu_valid_in;
            s1_d <= alu_f(alu_a, alu_b, alu_op);
            s2_v <= s1_v;
            s2_d <= s1_d;
        end
    end
    assign alu_valid_out = s2_v | force_vo;
    assign alu_result    = s2_d[15:0];
    assign alu_zero      = s2_d[16];
    assign alu_negative  = s2_d[17];
    assign alu_overflow  = s2_d[18];

    // scoreboard: push on accept, pop on retire, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready)
                sb.push_back({cmd_tag, alu_f(cmd_a, cmd_b, cmd_op)});
            if (rsp_valid && rsp_ready) begin
                logic [22:0] got;
                logic [22:0] exp;
                got = {rsp_tag, rsp_flags, rsp_result};
                exp = 23'h7FFFFF;
                if (sb.size() > 0) exp = sb.pop_front();
                checks++;
                assert (got === exp) else begin
                    failures++;
                    $error("FAIL sb_rsp observed=%06h expected=%06h", got, exp);
                end
                rsp_log.push_back(got);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic [3:0] tag);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) chk("send_timeout", {31'b0, cmd_ready}, 32'd1);
        step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; force_vo = 1'b0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        rsp_ready = 1'b0;
        repeat (3) step();

        // reset state
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_alu_vin", {31'b0, alu_valid_in}, 0);
        chk("rst_err", {31'b0, err_orphan}, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // 1: single ADD, latency
        rsp_ready = 1'b1;
        send(16'h0003, 16'h0004, 3'd0, 4'd5);
        cmd_valid = 1'b0;
        chk("t1_vin_n1", {31'b0, alu_valid_in}, 1);
        chk("t1_alu_a", {16'b0, alu_a}, 32'h3);
        chk("t1_alu_b", {16'b0, alu_b}, 32'h4);
        chk("t1_busy", {31'b0, busy}, 1);
        step();
        chk("t1_vin_n2", {31'b0, alu_valid_in}, 0);
        chk("t1_alu_a_hold", {16'b0, alu_a}, 32'h3);
        chk("t1_rsp_n2", {31'b0, rsp_valid}, 0);
        step();
        chk("t1_rsp_n3", {31'b0, rsp_valid}, 0);
        step();
        chk("t1_rsp_n4", {31'b0, rsp_valid}, 1);
        chk("t1_result", {16'b0, rsp_result}, 32'h7);
        chk("t1_flags", {29'b0, rsp_flags}, 0);
        chk("t1_tag", {28'b0, rsp_tag}, 5);
        step();
        chk("t1_rsp_gone", {31'b0, rsp_valid}, 0);
        chk("t1_busy_end", {31'b0, busy}, 0);

        // 2: back-to-back stream, in-order tags
        base = rsp_log.size();
        for (int t = 0; t < 8; t++) begin
            if (t < 4) chk("t2_rdy", {31'b0, cmd_ready}, 1);
            send(16'(t * 300), 16'(t + 1), 3'(t), 4'(t));
        end
        cmd_valid = 1'b0;
        wait_idle();
        step();
        chk("t2_rsp_count", rsp_log.size() - base, 8);

        // 3: fill with rsp_ready low, then drain
        rsp_ready = 1'b0;
        base = rsp_log.size();
        for (int t = 0; t < 6; t++) begin
            if (t == 4) chk("t3_full", {31'b0, cmd_ready}, 0);
            cmd_valid = 1'b1; cmd_a = 16'(t + 1); cmd_b = 16'h0001; cmd_op = 3'd0; cmd_tag = 4'(t);
            step();
        end
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("t3_rsp_valid", {31'b0, rsp_valid}, 1);
        chk("t3_tag0", {28'b0, rsp_tag}, 0);
        chk("t3_res0", {16'b0, rsp_result}, 32'h2);
        repeat (3) step();
        chk("t3_tag0_hold", {28'b0, rsp_tag}, 0);
        chk("t3_res0_hold", {16'b0, rsp_result}, 32'h2);
        chk("t3_still_full", {31'b0, cmd_ready}, 0);
        rsp_ready = 1'b1;
        step();
        chk("t3_rdy_back", {31'b0, cmd_ready}, 1);
        wait_idle();
        step();
        chk("t3_rsp_count", rsp_log.size() - base, 4);

        // 4: flag cases
        base = rsp_log.size();
        send(16'h0000, 16'h0001, 3'd1, 4'd1);
        send(16'h00F0, 16'h0F00, 3'd2, 4'd2);
        send(16'h8000, 16'h0001, 3'd7, 4'd3);
        cmd_valid = 1'b0;
        wait_idle();
        step();
        chk("t4_count", rsp_log.size() - base, 3);
        if (rsp_log.size() - base == 3) begin
            chk("t4_sub", {9'b0, rsp_log[base]},     {9'b0, 4'd1, 3'b110, 16'hFFFF});
            chk("t4_and", {9'b0, rsp_log[base + 1]}, {9'b0, 4'd2, 3'b001, 16'h0000});
            chk("t4_slt", {9'b0, rsp_log[base + 2]}, {9'b0, 4'd3, 3'b000, 16'h0001});
        end

        // 5: orphan result
        chk("t5_err_pre", {31'b0, err_orphan}, 0);
        force_vo = 1'b1;
        step();
        force_vo = 1'b0;
        chk("t5_err", {31'b0, err_orphan}, 1);
        chk("t5_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        repeat (3) step();
        chk("t5_err_sticky", {31'b0, err_orphan}, 1);
        base = rsp_log.size();
        send(16'h1234, 16'h1111, 3'd4, 4'd9);
        cmd_valid = 1'b0;
        wait_idle();
        step();
        chk("t5_after_count", rsp_log.size() - base, 1);

        // 6: async reset mid-operation
        rsp_ready = 1'b0;
        send(16'h0011, 16'h0022, 3'd0, 4'd4);
        send(16'h0033, 16'h0044, 3'd3, 4'd6);
        send(16'h0055, 16'h0066, 3'd4, 4'd7);
        cmd_valid = 1'b0;
        repeat (4) step();
        chk("t6_pre_rsp", {31'b0, rsp_valid}, 1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("t6_rsp_tag", {28'b0, rsp_tag}, 0);
        chk("t6_rsp_result", {16'b0, rsp_result}, 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_err", {31'b0, err_orphan}, 0);
        chk("t6_alu_a", {16'b0, alu_a}, 0);
        chk("t6_alu_op", {29'b0, alu_op}, 0);
        chk("t6_cmd_ready", {31'b0, cmd_ready}, 1);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_no_rsp", {31'b0, rsp_valid}, 0);
        end
        rsp_ready = 1'b1;
        base = rsp_log.size();
        send(16'h0100, 16'h0001, 3'd6, 4'd11);
        cmd_valid = 1'b0;
        wait_idle();
        step();
        chk("t6_new_count", rsp_log.size() - base, 1);
        chk("t6_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
